// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and instruction memory.
// Requests use valid/ready; responses come back later, one per accepted request.
interface fetch_stage_if;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [63:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;

    modport master (
        output ImemReqValid,
        output ImemAddr,
        input  ImemReqReady,
        input  ImemRspValid,
        input  ImemRspData
    );

    modport slave (
        input  ImemReqValid,
        input  ImemAddr,
        output ImemReqReady,
        output ImemRspValid,
        output ImemRspData
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: single-outstanding imem requests,
// a one-entry hold buffer for responses that arrive during a decode stall, and redirect handling.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                clk,
    input  logic                reset,
    fetch_stage_if.master       imem,
    input  logic                StallF,
    input  logic                StallD,
    input  logic                FlushD,
    input  logic                PCSrcE,
    input  logic [63:0]         PCTargetE,
    output logic [31:0]         InstrD,
    output logic [63:0]         PCD,
    output logic [63:0]         PCPlus4D,
    output logic                ValidD
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_KILL
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [63:0] r_pcF;
    logic [63:0] r_pcPend;

    logic        r_holdValid;
    logic [31:0] r_holdInstr;
    logic [63:0] r_holdPC;

    logic [31:0] r_instrD;
    logic [63:0] r_pcD;
    logic [63:0] r_pcPlus4D;
    logic        r_validD;

    logic        w_reqValid;
    logic        w_hs;
    logic        w_rspUse;
    logic        w_rspToHold;

    // The WAIT term lets a new request leave in the same cycle its predecessor's response lands.
    assign w_reqValid = !reset && !StallF && !PCSrcE && !r_holdValid &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_WAIT) && imem.ImemRspValid && !StallD));
    assign w_hs        = w_reqValid && imem.ImemReqReady;
    assign w_rspUse    = (r_state == S_WAIT) && imem.ImemRspValid && !PCSrcE;
    assign w_rspToHold = w_rspUse && StallD;

    assign imem.ImemReqValid = w_reqValid;
    assign imem.ImemAddr     = r_pcF;

    assign InstrD   = r_instrD;
    assign PCD      = r_pcD;
    assign PCPlus4D = r_pcPlus4D;
    assign ValidD   = r_validD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.ImemRspValid) begin
                    w_nextState = w_hs ? S_WAIT : S_IDLE;
                end else if (PCSrcE) begin
                    w_nextState = S_KILL;
                end
            end
            S_KILL: begin
                if (imem.ImemRspValid) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcF    <= RESET_PC;
            r_pcPend <= 64'h0;
        end else begin
            if (PCSrcE) begin
                r_pcF <= PCTargetE;
            end else if (w_hs) begin
                r_pcF <= r_pcF + 64'd4;
            end
            if (w_hs) begin
                r_pcPend <= r_pcF;
            end
        end
    end

    // A redirect makes any buffered instruction stale, so it wins over capture and drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_holdValid <= 1'b0;
            r_holdInstr <= NOP_INSTR;
            r_holdPC    <= 64'h0;
        end else if (PCSrcE) begin
            r_holdValid <= 1'b0;
        end else if (w_rspToHold) begin
            r_holdValid <= 1'b1;
            r_holdInstr <= imem.ImemRspData;
            r_holdPC    <= r_pcPend;
        end else if (r_holdValid && !FlushD && !StallD) begin
            r_holdValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_validD   <= 1'b0;
            r_instrD   <= NOP_INSTR;
            r_pcD      <= 64'h0;
            r_pcPlus4D <= 64'h0;
        end else if (FlushD) begin
            r_validD <= 1'b0;
            r_instrD <= NOP_INSTR;
        end else if (StallD) begin
            r_validD <= r_validD;
        end else if (r_holdValid) begin
            r_validD   <= 1'b1;
            r_instrD   <= r_holdInstr;
            r_pcD      <= r_holdPC;
            r_pcPlus4D <= r_holdPC + 64'd4;
        end else if (w_rspUse) begin
            r_validD   <= 1'b1;
            r_instrD   <= imem.ImemRspData;
            r_pcD      <= r_pcPend;
            r_pcPlus4D <= r_pcPend + 64'd4;
        end else begin
            r_validD <= 1'b0;
            r_instrD <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-configurable instruction memory, directed scenarios,
// and a randomized run checked against the program-order PC stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        stallF, stallD, flushD, pcSrcE;
    logic [63:0] pcTargetE;
    logic [31:0] InstrD;
    logic [63:0] PCD, PCPlus4D;
    logic        ValidD;

    fetch_stage_if imemBus ();

    fetch_stage dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imemBus),
        .StallF   (stallF),
        .StallD   (stallD),
        .FlushD   (flushD),
        .PCSrcE   (pcSrcE),
        .PCTargetE(pcTargetE),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

    int errors = 0;
    int checks = 0;

    // Memory model state
    logic        memPend;
    logic [63:0] memAddr;
    int          memCnt;
    int          memLat;
    logic        memReadyVal;
    logic        memRandom;

    // Per-cycle samples
    logic        sValidD, sReqValid, sHs, sRspValid, sPendBefore;
    logic [31:0] sInstrD;
    logic [63:0] sPcD, sPcPlus4D, sReqAddr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memWord(input logic [63:0] a);
        case (a)
            64'h0:   memWord = 32'h00500093;
            64'h4:   memWord = 32'h00A00113;
            64'h8:   memWord = 32'h00F00193;
            default: memWord = a[31:0] ^ a[63:32] ^ 32'h5A5A0F0F;
        endcase
    endfunction

    // One clock cycle, entered and left at the falling edge: sample decode outputs, drive the
    // memory, sample the request, then advance the memory model at the rising edge.
    task automatic tick();
        sValidD     = ValidD;
        sInstrD     = InstrD;
        sPcD        = PCD;
        sPcPlus4D   = PCPlus4D;
        sPendBefore = memPend;
        if (memPend && memCnt == 0) begin
            imemBus.ImemRspValid = 1'b1;
            imemBus.ImemRspData  = memWord(memAddr);
        end else begin
            imemBus.ImemRspValid = 1'b0;
            imemBus.ImemRspData  = $urandom;
        end
        imemBus.ImemReqReady = memRandom ? ($urandom_range(0, 3) != 0) : memReadyVal;
        #1;
        sReqValid = imemBus.ImemReqValid;
        sReqAddr  = imemBus.ImemAddr;
        sRspValid = imemBus.ImemRspValid;
        sHs       = sReqValid && imemBus.ImemReqReady;
        @(posedge clk);
        if (sRspValid) begin
            memPend = 1'b0;
        end else if (memPend && memCnt != 0) begin
            memCnt = memCnt - 1;
        end
        if (sHs) begin
            memPend = 1'b1;
            memAddr = sReqAddr;
            memCnt  = memRandom ? $urandom_range(0, 3) : memLat - 1;
        end
        @(negedge clk);
    endtask

    task automatic clearInputs();
        stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; pcSrcE = 1'b0; pcTargetE = 64'h0;
        imemBus.ImemRspValid = 1'b0;
        imemBus.ImemRspData  = 32'h0;
        imemBus.ImemReqReady = 1'b0;
        memPend = 1'b0; memAddr = 64'h0; memCnt = 0;
        memLat = 1; memReadyVal = 1'b1; memRandom = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ValidD, InstrD} !== {1'b0, NOP}) begin
            errors++; $display("[TB] FAIL reset_decode: got valid=%b instr=%h, expected 0/%h", ValidD, InstrD, NOP);
        end
        checks++;
        if ({PCD, PCPlus4D} !== 128'h0) begin
            errors++; $display("[TB] FAIL reset_pc: got PCD=%h PCPlus4D=%h, expected 0/0", PCD, PCPlus4D);
        end
        checks++;
        if ({imemBus.ImemReqValid, imemBus.ImemAddr} !== {1'b0, 64'h0}) begin
            errors++; $display("[TB] FAIL reset_req: got valid=%b addr=%h, expected 0/0", imemBus.ImemReqValid, imemBus.ImemAddr);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [63:0] ea;
        doReset();
        for (int i = 1; i <= 6; i++) begin
            tick();
            ea = 64'(4 * (i - 1));
            checks++;
            if ({sReqValid, sReqAddr} !== {1'b1, ea}) begin
                errors++; $display("[TB] FAIL zw_req%0d: got valid=%b addr=%h, expected 1/%h", i, sReqValid, sReqAddr, ea);
            end
            if (i >= 3) begin
                checks++;
                if (sValidD !== 1'b1) begin
                    errors++; $display("[TB] FAIL zw_valid%0d: got %b, expected 1", i, sValidD);
                end
            end
            if (i == 3) begin
                checks++;
                if ({sInstrD, sPcD} !== {32'h00500093, 64'h0}) begin
                    errors++; $display("[TB] FAIL zw_first: got %h/%h, expected 00500093/0", sInstrD, sPcD);
                end
            end
            if (i == 4) begin
                checks++;
                if ({sInstrD, sPcD, sPcPlus4D} !== {32'h00A00113, 64'h4, 64'h8}) begin
                    errors++; $display("[TB] FAIL zw_second: got %h/%h/%h, expected 00a00113/4/8", sInstrD, sPcD, sPcPlus4D);
                end
            end
        end
    endtask

    task automatic test_slow_mem();
        int validSeen = 0;
        int dupReq    = 0;
        doReset();
        memReadyVal = 1'b0;
        memLat      = 4;
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) memReadyVal = 1'b1;
            tick();
            if (i <= 8 && sValidD) validSeen++;
            if (i >= 5 && i <= 7 && sReqValid) dupReq++;
            if (i <= 3) begin
                checks++;
                if ({sReqValid, sHs, sReqAddr} !== {1'b1, 1'b0, 64'h0}) begin
                    errors++; $display("[TB] FAIL slow_hold%0d: got valid=%b hs=%b addr=%h, expected 1/0/0", i, sReqValid, sHs, sReqAddr);
                end
            end
            if (i == 8) begin
                checks++;
                if ({sRspValid, sReqValid, sReqAddr} !== {1'b1, 1'b1, 64'h4}) begin
                    errors++; $display("[TB] FAIL slow_next: got rsp=%b req=%b addr=%h, expected 1/1/4", sRspValid, sReqValid, sReqAddr);
                end
            end
            if (i == 9) begin
                checks++;
                if ({sValidD, sInstrD, sPcD} !== {1'b1, 32'h00500093, 64'h0}) begin
                    errors++; $display("[TB] FAIL slow_arrive: got %b/%h/%h, expected 1/00500093/0", sValidD, sInstrD, sPcD);
                end
            end
        end
        checks++;
        if (validSeen != 0) begin
            errors++; $display("[TB] FAIL slow_bubble: got %0d valid cycles, expected 0", validSeen);
        end
        checks++;
        if (dupReq != 0) begin
            errors++; $display("[TB] FAIL slow_dup: got %0d extra requests, expected 0", dupReq);
        end
    endtask

    task automatic test_stall_hold();
        int reqDuringHold = 0;
        doReset();
        for (int i = 1; i <= 7; i++) begin
            stallD = (i == 4 || i == 5);
            tick();
            if (i >= 4 && i <= 6 && sReqValid) reqDuringHold++;
            if (i == 5 || i == 6) begin
                checks++;
                if ({sValidD, sInstrD, sPcD} !== {1'b1, 32'h00A00113, 64'h4}) begin
                    errors++; $display("[TB] FAIL hold_prior%0d: got %b/%h/%h, expected 1/00a00113/4", i, sValidD, sInstrD, sPcD);
                end
            end
            if (i == 7) begin
                checks++;
                if ({sValidD, sInstrD, sPcD} !== {1'b1, 32'h00F00193, 64'h8}) begin
                    errors++; $display("[TB] FAIL hold_drain: got %b/%h/%h, expected 1/00f00193/8", sValidD, sInstrD, sPcD);
                end
                checks++;
                if ({sReqValid, sReqAddr} !== {1'b1, 64'hC}) begin
                    errors++; $display("[TB] FAIL hold_nextreq: got %b/%h, expected 1/c", sReqValid, sReqAddr);
                end
            end
        end
        stallD = 1'b0;
        checks++;
        if (reqDuringHold != 0) begin
            errors++; $display("[TB] FAIL hold_noreq: got %0d requests, expected 0", reqDuringHold);
        end
    endtask

    task automatic test_redirect();
        int staleSeen = 0;
        int reqInKill = 0;
        doReset();
        for (int i = 1; i <= 12; i++) begin
            memLat    = (i == 5) ? 3 : 1;
            pcSrcE    = (i == 6);
            flushD    = (i == 6);
            pcTargetE = 64'h100;
            tick();
            if (i >= 6 && i <= 8 && sReqValid) reqInKill++;
            if (i >= 6 && sValidD && sPcD == 64'h10) staleSeen++;
            if (i == 9) begin
                checks++;
                if ({sReqValid, sReqAddr} !== {1'b1, 64'h100}) begin
                    errors++; $display("[TB] FAIL redir_req: got %b/%h, expected 1/100", sReqValid, sReqAddr);
                end
            end
            if (i == 11) begin
                checks++;
                if ({sValidD, sInstrD, sPcD} !== {1'b1, memWord(64'h100), 64'h100}) begin
                    errors++; $display("[TB] FAIL redir_dec: got %b/%h/%h, expected 1/%h/100", sValidD, sInstrD, sPcD, memWord(64'h100));
                end
            end
        end
        pcSrcE = 1'b0; flushD = 1'b0;
        checks++;
        if (reqInKill != 0) begin
            errors++; $display("[TB] FAIL redir_kill: got %0d requests, expected 0", reqInKill);
        end
        checks++;
        if (staleSeen != 0) begin
            errors++; $display("[TB] FAIL redir_stale: got %0d stale decodes, expected 0", staleSeen);
        end
    endtask

    task automatic test_flush_stall();
        doReset();
        for (int i = 1; i <= 5; i++) begin
            stallD = (i == 4);
            flushD = (i == 4);
            tick();
            if (i == 4) begin
                checks++;
                if (sValidD !== 1'b1) begin
                    errors++; $display("[TB] FAIL fs_pre: got %b, expected 1", sValidD);
                end
            end
            if (i == 5) begin
                checks++;
                if ({sValidD, sInstrD} !== {1'b0, NOP}) begin
                    errors++; $display("[TB] FAIL fs_bubble: got %b/%h, expected 0/%h", sValidD, sInstrD, NOP);
                end
            end
        end
        stallD = 1'b0; flushD = 1'b0;
    endtask

    task automatic test_wrap();
        doReset();
        for (int i = 1; i <= 4; i++) begin
            pcSrcE    = (i == 1);
            flushD    = (i == 1);
            pcTargetE = 64'hFFFF_FFFF_FFFF_FFFC;
            tick();
            if (i == 2) begin
                checks++;
                if ({sReqValid, sReqAddr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
                    errors++; $display("[TB] FAIL wrap_req: got %b/%h, expected 1/fffffffffffffffc", sReqValid, sReqAddr);
                end
            end
            if (i == 3) begin
                checks++;
                if ({sReqValid, sReqAddr} !== {1'b1, 64'h0}) begin
                    errors++; $display("[TB] FAIL wrap_next: got %b/%h, expected 1/0", sReqValid, sReqAddr);
                end
            end
            if (i == 4) begin
                checks++;
                if ({sValidD, sPcD, sPcPlus4D} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0}) begin
                    errors++; $display("[TB] FAIL wrap_dec: got %b/%h/%h, expected 1/fffffffffffffffc/0", sValidD, sPcD, sPcPlus4D);
                end
            end
        end
        pcSrcE = 1'b0; flushD = 1'b0;
    endtask

    task automatic test_async_reset();
        doReset();
        for (int i = 1; i <= 4; i++) tick();
        checks++;
        if ({ValidD, imemBus.ImemReqValid} !== 2'b11) begin
            errors++; $display("[TB] FAIL ar_pre: got valid=%b req=%b, expected 1/1", ValidD, imemBus.ImemReqValid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, NOP, 64'h0, 64'h0}) begin
            errors++; $display("[TB] FAIL ar_decode: got %b/%h/%h/%h, expected 0/%h/0/0", ValidD, InstrD, PCD, PCPlus4D, NOP);
        end
        checks++;
        if ({imemBus.ImemReqValid, imemBus.ImemAddr} !== {1'b0, 64'h0}) begin
            errors++; $display("[TB] FAIL ar_req: got %b/%h, expected 0/0", imemBus.ImemReqValid, imemBus.ImemAddr);
        end
        clearInputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference: instructions reach decode exactly once, in program order (PC+4 unless
    // redirected), each carrying memWord(PC); requests follow the same address stream.
    task automatic test_random();
        logic [63:0] expD, expReq;
        logic        prevHold;
        logic [96:0] prevVec;
        int          delivered = 0;
        doReset();
        memRandom = 1'b1;
        expD = 64'h0; expReq = 64'h0; prevHold = 1'b0; prevVec = '0;
        for (int c = 0; c < 3000; c++) begin
            stallF    = ($urandom_range(0, 9) == 0);
            stallD    = ($urandom_range(0, 4) == 0);
            pcSrcE    = ($urandom_range(0, 32) == 0);
            flushD    = pcSrcE;
            pcTargetE = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom} & ~64'h3;
            tick();
            if (prevHold) begin
                checks++;
                if ({sValidD, sInstrD, sPcD} !== prevVec) begin
                    errors++; $display("[TB] FAIL rnd_stall c=%0d: got %b/%h/%h, expected %h", c, sValidD, sInstrD, sPcD, prevVec);
                end
            end else if (sValidD) begin
                checks++;
                if ({sPcD, sInstrD, sPcPlus4D} !== {expD, memWord(expD), expD + 64'd4}) begin
                    errors++; $display("[TB] FAIL rnd_stream c=%0d: got %h/%h/%h, expected %h/%h/%h", c, sPcD, sInstrD, sPcPlus4D, expD, memWord(expD), expD + 64'd4);
                end
                expD = expD + 64'd4;
                delivered++;
            end else begin
                checks++;
                if (sInstrD !== NOP) begin
                    errors++; $display("[TB] FAIL rnd_bubble c=%0d: got %h, expected %h", c, sInstrD, NOP);
                end
            end
            prevHold = stallD && !flushD;
            prevVec  = {sValidD, sInstrD, sPcD};
            if (sReqValid) begin
                checks++;
                if (sReqAddr !== expReq) begin
                    errors++; $display("[TB] FAIL rnd_addr c=%0d: got %h, expected %h", c, sReqAddr, expReq);
                end
                checks++;
                if ((sPendBefore && !sRspValid) || stallF || pcSrcE) begin
                    errors++; $display("[TB] FAIL rnd_reqrule c=%0d: got req with pend=%b rsp=%b stallF=%b redirect=%b, expected no req", c, sPendBefore, sRspValid, stallF, pcSrcE);
                end
            end
            if (sHs) expReq = expReq + 64'd4;
            if (pcSrcE) begin
                expReq = pcTargetE;
                expD   = pcTargetE;
            end
        end
        clearInputs();
        checks++;
        if (delivered < 200) begin
            errors++; $display("[TB] FAIL rnd_progress: got %0d instructions, expected at least 200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_stall_hold();
        test_redirect();
        test_flush_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the RV64I+Zba five-stage core. It owns the fetch PC, issues single-outstanding requests to instruction memory over a valid/ready handshake, and absorbs variable memory latency and decode stalls with a one-entry hold buffer. It presents InstrD/PCD/PCPlus4D to the decode stage, where the control unit and immediate generator consume them. Branch and jump redirects from Execute, and stall/flush controls from the hazard unit, are honoured here.

## Interface
- RESET_PC, 64'h0: fetch address after reset.
- NOP_INSTR, 32'h00000013: encoding driven on InstrD for a bubble (addi x0,x0,0).

- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ImemReqValid  out  1  fetch request valid.
- ImemReqReady  in  1  memory accepts the request.
- ImemAddr  out  64  request address; always equals PCF.
- ImemRspValid  in  1  instruction response valid; exactly one per accepted request, never in the same cycle as its request.
- ImemRspData  in  32  instruction word.
- StallF  in  1  hazard unit: hold PCF, issue no request.
- StallD  in  1  hazard unit: hold the decode register.
- FlushD  in  1  hazard unit: bubble the decode register.
- PCSrcE  in  1  Execute redirect (taken branch, JAL, JALR).
- PCTargetE  in  64  redirect target.
- InstrD  out  32  instruction in Decode.
- PCD  out  64  PC of InstrD.
- PCPlus4D  out  64  PCD+4, modulo 2^64.
- ValidD  out  1  InstrD is a real instruction (0 = bubble).

## Operation
- Registers: PCF, PCPend (address of the outstanding request), state, HoldValid/HoldInstr/HoldPC, and the decode register.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response will be used.
  - KILL: one request outstanding; it was redirected away, so its response is discarded.
- Req handshake (hs) = ImemReqValid && ImemReqReady. On hs: PCPend <= PCF and PCF <= PCF+4 (64-bit wrap).
- ImemReqValid = !reset && !StallF && !PCSrcE && !HoldValid && (state==IDLE || (state==WAIT && ImemRspValid && !StallD)). The response-cycle term is a combinational path that gives back-to-back fetch.
- Transitions:
  - IDLE: hs -> WAIT.
  - WAIT:
    - ImemRspValid with hs -> WAIT.
    - ImemRspValid without hs -> IDLE.
    - !ImemRspValid && PCSrcE -> KILL.
    - Otherwise stay in WAIT.
  - KILL: ImemRspValid -> IDLE, data dropped. No requests are issued in KILL.
- Response use (state WAIT, ImemRspValid, !PCSrcE):
  - Goes to the decode register if !StallD.
  - Otherwise goes to the hold buffer (HoldInstr = data, HoldPC = PCPend).
  - HoldValid can only be 0 at this point, because no request is issued while it is set.
- Redirect (PCSrcE=1):
  - PCF <= PCTargetE.
  - HoldValid <= 0.
  - Any response arriving this cycle is dropped.
  - No request is issued this cycle.
  - Redirect overrides StallF.
- Decode register update, in priority order:
  1. FlushD -> ValidD=0, InstrD=NOP_INSTR. FlushD overrides StallD.
  2. StallD -> hold all D outputs.
  3. HoldValid -> load hold buffer, clear HoldValid.
  4. Usable response -> load it.
  5. Otherwise bubble (ValidD=0, InstrD=NOP_INSTR).
- On every load, PCD gets the source PC and PCPlus4D gets the source PC+4.
- ImemRspValid in IDLE is a protocol violation and is ignored: no state change.

## Timing
- Reset (async assert) values:
  - PCF=RESET_PC, state=IDLE, HoldValid=0.
  - ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - ImemReqValid=0 while reset is high.
- Reset mid-request: the outstanding transaction is forgotten. The memory side is reset on the same signal.
- The first request is issued in the first cycle after reset deasserts, with ImemAddr=RESET_PC.
- Latency: a request accepted in cycle n with response in cycle n+k is visible on InstrD in cycle n+k+1 (if !StallD).
- Throughput: with zero-wait memory (ready=1, response next cycle), one instruction per cycle.
- Redirect in cycle n: the request to PCTargetE is issued in n+1. If a stale request is still outstanding, it is issued one cycle after the KILL response returns.
- Hold buffer: never more than one entry. No request is issued while it is valid.

## Test plan
- Reset release, memory ready=1 and 1-cycle latency returning words 0x00500093, 0x00A00113, ... -> ImemAddr 0x0, 0x4, 0x8 on consecutive cycles; InstrD/PCD = 0x00500093/0x0, then 0x00A00113/0x4; ValidD=1 each cycle from cycle 3.
- ImemReqReady low for 3 cycles, then response latency 4 -> ImemAddr holds 0x0; a single instruction arrives; ValidD=0 during the wait; no duplicate request.
- StallD high for 2 cycles as the response for PC 0x8 arrives -> the response lands in the hold buffer; InstrD/PCD hold the prior instruction; when StallD drops, PCD=0x8 and the next request is 0xC.
- PCSrcE=1, PCTargetE=0x100 while a request for 0x10 is outstanding -> state KILL; the 0x10 response is never on InstrD; the next ImemAddr is 0x100; PCD becomes 0x100.
- FlushD and StallD together -> ValidD=0, InstrD=0x00000013 next cycle.
- PCF=64'hFFFF_FFFF_FFFF_FFFC fetch -> PCPlus4D=0 and next ImemAddr=0.
- Async reset asserted mid-WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.
